// File: rtl/pwm_output_stage_if.sv
// Signal bundle between the PWM counter/config side and pwm_output_stage.
// PWM_DEADTIME_EN adds the dead-time input, the complementary output and the DTW parameter.
interface pwm_output_stage_if #(
    parameter int CW = 16
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DTW = 8
`endif
);
    logic          pwm_en;
    logic [1:0]    functions;
    logic [CW-1:0] compare1;
    logic [CW-1:0] compare2;
    logic [CW-1:0] period;
    logic [CW-1:0] count_val;
    logic          pwm_out;
    logic          update_pending;
`ifdef PWM_DEADTIME_EN
    logic [DTW-1:0] deadtime;
    logic           pwm_out_n;
`endif

    modport master (
        output pwm_en, functions, compare1, compare2, period, count_val,
`ifdef PWM_DEADTIME_EN
        output deadtime,
        input  pwm_out_n,
`endif
        input  pwm_out, update_pending
    );

    modport slave (
        input  pwm_en, functions, compare1, compare2, period, count_val,
`ifdef PWM_DEADTIME_EN
        input  deadtime,
        output pwm_out_n,
`endif
        output pwm_out, update_pending
    );
endinterface

// File: rtl/pwm_output_stage.sv
// PWM compare-and-drive stage with shadow compare registers reloaded at the period boundary.
// Define PWM_DEADTIME_EN to add the dead-time generator and the complementary output.
module pwm_output_stage #(
    parameter int CW = 16
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DTW = 8
`endif
) (
    input logic              clk,
    input logic              rst_n,
    pwm_output_stage_if.slave bus
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] c1_s;
    logic [CW-1:0] c2_s;
    logic [1:0]    fn_s;
    logic          en_q;
    logic          ideal_q;

    logic          raw;
    logic          raw_gated;
    logic          boundary;
    logic          load;

    // Boundary catches both the up-count wrap and a down-count reaching zero.
    always_comb begin
        boundary = (bus.count_val == '0) && (count_q != '0);
        load     = bus.pwm_en && (boundary || !en_q);
    end

    always_comb begin
        raw = 1'b0;
        case (fn_s)
            2'b00:   raw = (bus.count_val < c1_s);
            2'b01:   raw = (bus.count_val >= c1_s);
            default: raw = (c1_s < c2_s) && (bus.count_val >= c1_s) && (bus.count_val < c2_s);
        endcase
        raw_gated = bus.pwm_en ? raw : 1'b0;
    end

    assign bus.update_pending = (bus.compare1 != c1_s) || (bus.compare2 != c2_s) ||
                                (bus.functions != fn_s);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            c1_s    <= '0;
            c2_s    <= '0;
            fn_s    <= '0;
            en_q    <= 1'b0;
            ideal_q <= 1'b0;
        end else begin
            count_q <= bus.count_val;
            en_q    <= bus.pwm_en;
            ideal_q <= raw_gated;
            if (load) begin
                c1_s <= bus.compare1;
                c2_s <= bus.compare2;
                fn_s <= bus.functions;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DTW-1:0] dt_cnt;

    // A toggle arriving mid dead-time restarts the blanking window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dt_cnt <= '0;
        end else if (raw_gated != ideal_q) begin
            dt_cnt <= bus.deadtime;
        end else if (dt_cnt != '0) begin
            dt_cnt <= dt_cnt - 1'b1;
        end
    end

    assign bus.pwm_out   = ideal_q && (dt_cnt == '0);
    assign bus.pwm_out_n = !ideal_q && en_q && (dt_cnt == '0);
`else
    assign bus.pwm_out = ideal_q;
`endif

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: duty-cycle vector table plus a per-cycle reference model
// feeding a scoreboard queue, with hand sequences for buffering, enable, reset and dead-time corners.
module tb_pwm_output_stage;
    localparam int CW = 16;
`ifdef PWM_DEADTIME_EN
    localparam int DTW = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef PWM_DEADTIME_EN
    pwm_output_stage_if #(.CW(CW), .DTW(DTW)) bus ();
    pwm_output_stage #(.CW(CW), .DTW(DTW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    pwm_output_stage_if #(.CW(CW)) bus ();
    pwm_output_stage #(.CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] m_cq, m_c1, m_c2;
    logic [1:0]    m_fn;
    logic          m_enq, m_ideal;
    int            m_dt;

    typedef struct {
        logic o;
        logic on;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0] fn;
        int         c1;
        int         c2;
        int         exp_high;
    } vec_t;
    vec_t vt[8];

    int cnt;
    int per;
    bit down;
    int highs;
    logic last_out;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_raw(input logic [1:0] fn, input logic [CW-1:0] c1,
                                       input logic [CW-1:0] c2, input logic [CW-1:0] cv);
        if (fn == 2'b00) return cv < c1;
        if (fn == 2'b01) return cv >= c1;
        if (c1 >= c2) return 1'b0;
        return (cv >= c1) && (cv < c2);
    endfunction

    // One clock with the inputs currently on the bus: model step, push, edge, pop and compare.
    task automatic tick();
        exp_t e;
        exp_t got;
        logic rg, bnd, ld;
        #1;
        check("update_pending", bus.update_pending,
              (bus.compare1 != m_c1) || (bus.compare2 != m_c2) || (bus.functions != m_fn));
        if (!rst_n) begin
            m_cq = '0; m_c1 = '0; m_c2 = '0; m_fn = '0;
            m_enq = 1'b0; m_ideal = 1'b0; m_dt = 0;
        end else begin
            rg  = bus.pwm_en ? model_raw(m_fn, m_c1, m_c2, bus.count_val) : 1'b0;
            bnd = (bus.count_val == 0) && (m_cq != 0);
            ld  = bus.pwm_en && (bnd || !m_enq);
`ifdef PWM_DEADTIME_EN
            if (rg != m_ideal) m_dt = int'(bus.deadtime);
            else if (m_dt != 0) m_dt = m_dt - 1;
`endif
            m_ideal = rg;
            if (ld) begin
                m_c1 = bus.compare1;
                m_c2 = bus.compare2;
                m_fn = bus.functions;
            end
            m_cq  = bus.count_val;
            m_enq = bus.pwm_en;
        end
`ifdef PWM_DEADTIME_EN
        e.o  = m_ideal && (m_dt == 0);
        e.on = !m_ideal && m_enq && (m_dt == 0);
`else
        e.o  = m_ideal;
        e.on = 1'b0;
`endif
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check("pwm_out", bus.pwm_out, got.o);
`ifdef PWM_DEADTIME_EN
        check("pwm_out_n", bus.pwm_out_n, got.on);
        check("no_overlap", bus.pwm_out && bus.pwm_out_n, 1'b0);
`endif
    endtask

    task automatic advance();
        bus.count_val = CW'(cnt);
        tick();
        highs += int'(bus.pwm_out);
        if (down) cnt = (cnt == 0) ? per : cnt - 1;
        else      cnt = (cnt >= per) ? 0 : cnt + 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < 40 && cnt != target; i++) advance();
        check_int("reach_count", cnt, target);
    endtask

    initial begin
        vt[0] = '{2'b00, 3, 0, 3};
        vt[1] = '{2'b01, 7, 0, 3};
        vt[2] = '{2'b10, 2, 6, 4};
        vt[3] = '{2'b11, 6, 2, 0};
        vt[4] = '{2'b00, 0, 0, 0};
        vt[5] = '{2'b00, 20, 0, 10};
        vt[6] = '{2'b01, 0, 0, 10};
        vt[7] = '{2'b01, 20, 0, 0};

        bus.pwm_en = 1'b0; bus.functions = 2'b00;
        bus.compare1 = '0; bus.compare2 = '0; bus.period = '0; bus.count_val = '0;
`ifdef PWM_DEADTIME_EN
        bus.deadtime = '0;
`endif
        m_cq = '0; m_c1 = '0; m_c2 = '0; m_fn = '0; m_enq = 1'b0; m_ideal = 1'b0; m_dt = 0;
        cnt = 0; per = 9; down = 1'b0; highs = 0;

        rst_n = 1'b0;
        run(3);
        check("reset_pwm_out", bus.pwm_out, 1'b0);
        check("reset_update_pending", bus.update_pending, 1'b0);

        rst_n = 1'b1;
        bus.period = CW'(per);
        bus.pwm_en = 1'b1;
        bus.compare1 = 16'd3;
        run(20);

        // Rising edge one cycle after the counter shows zero.
        advance_to(0);
        last_out = bus.pwm_out;
        check("low_before_wrap", last_out, 1'b0);
        advance();
        check("rise_after_zero", bus.pwm_out, 1'b1);

        for (int v = 0; v < 8; v++) begin
            bus.functions = vt[v].fn;
            bus.compare1  = CW'(vt[v].c1);
            bus.compare2  = CW'(vt[v].c2);
            run(20);
            highs = 0;
            run(10);
            check_int($sformatf("duty_vec%0d", v), highs, vt[v].exp_high);
        end

        // Double buffering: compare1 3 -> 8 mid-period.
        bus.functions = 2'b00; bus.compare1 = 16'd3; bus.compare2 = '0;
        run(20);
        advance_to(5);
        bus.compare1 = 16'd8;
        highs = 0;
        advance();
        check("pending_mid_period", bus.update_pending, 1'b1);
        advance_to(0);
        check_int("old_compare_tail", highs, 0);
        check("pending_before_wrap", bus.update_pending, 1'b1);
        advance();
        check("pending_cleared", bus.update_pending, 1'b0);
        check("wrap_uses_old", bus.pwm_out, 1'b1);
        highs = 1;
        run(9);
        check_int("new_compare_duty", highs, 8);

        // Down counter: reload only as the count reaches zero.
        down = 1'b1; bus.compare1 = 16'd3;
        run(20);
        highs = 0;
        run(10);
        check_int("down_duty", highs, 3);
        advance_to(6);
        bus.compare1 = 16'd5;
        for (int i = 0; i < 6; i++) begin
            advance();
            check("down_pending_hold", bus.update_pending, 1'b1);
        end
        check_int("down_at_zero", cnt, 0);
        advance();
        check("down_pending_cleared", bus.update_pending, 1'b0);
        down = 1'b0;
        cnt = 0;
        run(15);

        // Disable mid-high, then re-enable with a new compare.
        bus.compare1 = 16'd3;
        run(20);
        advance_to(1);
        bus.pwm_en = 1'b0;
        advance();
        check("disable_low", bus.pwm_out, 1'b0);
        run(5);
        check("disabled_low", bus.pwm_out, 1'b0);
        bus.pwm_en = 1'b1;
        bus.compare1 = 16'd6;
        advance();
        check("reenable_reload", bus.update_pending, 1'b0);
        run(20);
        highs = 0;
        run(10);
        check_int("reenable_duty", highs, 6);

        // Synchronous reset while the output is high.
        advance_to(2);
        advance();
        check("high_before_reset", bus.pwm_out, 1'b1);
        rst_n = 1'b0;
        advance();
        check("reset_mid_high", bus.pwm_out, 1'b0);
        rst_n = 1'b1;
        run(20);

        // Period zero: counter parked at 0, shadows keep their enable-time values.
        bus.pwm_en = 1'b0;
        per = 0; cnt = 0; bus.period = '0;
        run(3);
        bus.pwm_en = 1'b1; bus.compare1 = 16'd3;
        run(5);
        check("period0_high", bus.pwm_out, 1'b1);
        bus.compare1 = '0;
        run(5);
        check("period0_pending", bus.update_pending, 1'b1);
        check("period0_hold", bus.pwm_out, 1'b1);

`ifdef PWM_DEADTIME_EN
        per = 9; cnt = 0; bus.period = CW'(per);
        bus.pwm_en = 1'b0;
        run(2);
        bus.deadtime = 8'd2; bus.compare1 = 16'd4; bus.functions = 2'b00;
        bus.pwm_en = 1'b1;
        run(20);
        highs = 0;
        run(10);
        check_int("deadtime_duty", highs, 2);
        bus.deadtime = '0;
        run(20);
        for (int i = 0; i < 10; i++) begin
            advance();
            check("dt0_complement", bus.pwm_out_n, ~bus.pwm_out);
        end
        bus.pwm_en = 1'b0;
        run(3);
        check("disabled_n_low", bus.pwm_out_n, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
